// File: rtl/sep_blur_engine.sv
// Separable binomial blur: horizontal pass into a TAPS-deep row cache, then vertical pass.
// Define SEP_BLUR_ROUND_EN for round-half-up; default build truncates.
module sep_blur_engine #(
  parameter int PIXEL_W  = 8,
  parameter int OUT_COLS = 16,
  parameter int TAPS     = 5
) (
  input  logic                                 clk,
  input  logic                                 n_rst,
  input  logic                                 flush,
  input  logic                                 row_valid,
  output logic                                 row_ready,
  input  logic                                 row_first,
  input  logic [(OUT_COLS+TAPS-1)*PIXEL_W-1:0] row_in,
  output logic [OUT_COLS*PIXEL_W-1:0]          out_pix,
  output logic                                 out_valid,
  output logic                                 busy
);
  localparam int IN_W  = (OUT_COLS + TAPS - 1) * PIXEL_W;
  localparam int SHIFT = TAPS - 1;
  localparam int ACC_W = PIXEL_W + SHIFT;
  localparam int IDX_W = (OUT_COLS > 1) ? $clog2(OUT_COLS) : 1;
  localparam logic [IDX_W-1:0] LAST = IDX_W'(OUT_COLS - 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] HPASS = 2'd1;
  localparam logic [1:0] VPASS = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

`ifdef SEP_BLUR_ROUND_EN
  localparam logic [ACC_W-1:0] RND = ACC_W'(1) << (SHIFT - 1);
`else
  localparam logic [ACC_W-1:0] RND = '0;
`endif

  if (TAPS != 3 && TAPS != 5) begin : g_bad_taps
    $error("sep_blur_engine: TAPS must be 3 or 5");
  end

  // Binomial weight C(TAPS-1, k); weights sum to 2^SHIFT.
  function automatic logic [ACC_W-1:0] wt(input int k);
    int c;
    c = 1;
    for (int i = 0; i < k; i++) c = c * (SHIFT - i) / (i + 1);
    return ACC_W'(c);
  endfunction

  function automatic logic [PIXEL_W-1:0] blur(
    input logic [TAPS*PIXEL_W-1:0] win
  );
    logic [ACC_W-1:0] acc;
    acc = RND;
    for (int k = 0; k < TAPS; k++)
      acc = acc + wt(k) * ACC_W'(win[k*PIXEL_W +: PIXEL_W]);
    return PIXEL_W'(acc >> SHIFT);
  endfunction

  logic [1:0]         state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [IN_W-1:0]    row_q, row_d;
  logic               first_q, first_d;
  logic               out_valid_q, out_valid_d;
  logic [PIXEL_W-1:0] cache_q [TAPS][OUT_COLS];
  logic [PIXEL_W-1:0] cache_d [TAPS][OUT_COLS];
  logic [PIXEL_W-1:0] shadow_q [OUT_COLS];
  logic [PIXEL_W-1:0] shadow_d [OUT_COLS];
  logic [PIXEL_W-1:0] out_pix_q [OUT_COLS];
  logic [PIXEL_W-1:0] out_pix_d [OUT_COLS];

  logic [TAPS*PIXEL_W-1:0] h_win, v_win;
  logic [PIXEL_W-1:0]      h_pix, v_pix;

  assign h_win = row_q[int'(idx_q)*PIXEL_W +: TAPS*PIXEL_W];

  always_comb begin
    v_win = '0;
    for (int k = 0; k < TAPS; k++)
      v_win[k*PIXEL_W +: PIXEL_W] = cache_q[k][idx_q];
  end

  assign h_pix = blur(h_win);
  assign v_pix = blur(v_win);

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    row_d       = row_q;
    first_d     = first_q;
    cache_d     = cache_q;
    shadow_d    = shadow_q;
    out_pix_d   = out_pix_q;
    out_valid_d = 1'b0;
    if (flush) begin
      state_d = IDLE;
      idx_d   = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (row_valid) begin
            state_d = HPASS;
            row_d   = row_in;
            first_d = row_first;
            for (int r = 1; r < TAPS; r++) cache_d[r] = cache_q[r-1];
          end
        end
        HPASS: begin
          // First row of a frame fills every cache row to replicate the top edge.
          for (int r = 0; r < TAPS; r++)
            if (r == 0 || first_q) cache_d[r][idx_q] = h_pix;
          idx_d = idx_q + IDX_W'(1);
          if (idx_q == LAST) begin
            state_d = VPASS;
            idx_d   = '0;
          end
        end
        VPASS: begin
          shadow_d[idx_q] = v_pix;
          idx_d = idx_q + IDX_W'(1);
          if (idx_q == LAST) begin
            state_d     = DONE;
            idx_d       = '0;
            out_valid_d = 1'b1;
            out_pix_d   = shadow_d;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      row_q       <= '0;
      first_q     <= 1'b0;
      out_valid_q <= 1'b0;
      cache_q     <= '{default: '0};
      shadow_q    <= '{default: '0};
      out_pix_q   <= '{default: '0};
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      row_q       <= row_d;
      first_q     <= first_d;
      out_valid_q <= out_valid_d;
      cache_q     <= cache_d;
      shadow_q    <= shadow_d;
      out_pix_q   <= out_pix_d;
    end
  end

  for (genvar c = 0; c < OUT_COLS; c++) begin : g_out
    assign out_pix[c*PIXEL_W +: PIXEL_W] = out_pix_q[c];
  end

  assign row_ready = (state_q == IDLE) && !flush;
  assign out_valid = out_valid_q;
  assign busy      = (state_q != IDLE);

endmodule
